// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the round-robin BRAM read scheduler.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int MAX_RD_LAT = 4;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_rd_sched_rr_arbiter.sv
// Request vector + search start pointer -> one-hot grant.
// BRAM_RD_FIXED_PRIO_EN selects fixed lowest-index-wins priority and drops the pointer port.
module rr_arbiter
  import bram_rd_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]        req,
`ifndef BRAM_RD_FIXED_PRIO_EN
  input  logic [id_w(NUM_REQ)-1:0]  ptr,
`endif
  output logic [NUM_REQ-1:0]        gnt
);

  logic found;

`ifdef BRAM_RD_FIXED_PRIO_EN
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`else
  // Walk the requesters starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/bram_rd_sched.sv
// Shares one BRAM read port among NUM_REQ burst requesters; returns tagged, latency-aligned data.
// Define BRAM_RD_FIXED_PRIO_EN for fixed (lowest index) priority instead of round-robin.
module bram_rd_sched
  import bram_rd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          req_gnt,
  output logic                        bram_en,
  output logic [ADDR_W-1:0]           bram_addr,
  input  logic [DATA_W-1:0]           bram_dout,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid,
  output logic [id_w(NUM_REQ)-1:0]    data_id,
  output logic                        busy,
  output logic [NUM_REQ-1:0]          done
);

  localparam int ID_W = id_w(NUM_REQ);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
  logic [LEN_W-1:0]    rem_reg, rem_next;
  logic [ID_W-1:0]     owner_reg, owner_next;
  logic                zlen_done_reg, zlen_done_next;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_any;
  logic [ID_W-1:0]     arb_id;
  logic                issue_en;
  logic                issue_last;
  logic                pipe_busy;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [LEN_W-1:0]    len_arr  [NUM_REQ];

  logic                pipe_en_reg   [RD_LAT];
  logic [ID_W-1:0]     pipe_id_reg   [RD_LAT];
  logic                pipe_last_reg [RD_LAT];

  genvar gi;

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
  end

  // ---------------- arbitration ----------------
`ifndef BRAM_RD_FIXED_PRIO_EN
  logic [ID_W-1:0] ptr_reg;

  // Pointer holds the index one past the last winner; moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (state_reg == ARB && arb_any) begin
      if (arb_id == ID_W'(NUM_REQ - 1))
        ptr_reg <= '0;
      else
        ptr_reg <= arb_id + ID_W'(1);
    end
  end
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req),
`ifndef BRAM_RD_FIXED_PRIO_EN
    .ptr (ptr_reg),
`endif
    .gnt (arb_gnt)
  );

  assign arb_any = |arb_gnt;

  always_comb begin
    arb_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_id = ID_W'(i);
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      rem_reg       <= '0;
      owner_reg     <= '0;
      zlen_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      rem_reg       <= rem_next;
      owner_reg     <= owner_next;
      zlen_done_reg <= zlen_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    rem_next       = rem_reg;
    owner_next     = owner_reg;
    zlen_done_next = 1'b0;
    req_gnt        = '0;
    issue_en       = 1'b0;
    issue_last     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (|req) state_next = ARB;
      end
      ARB: begin
        // A requester that dropped its request before arbitration just returns us to IDLE.
        if (arb_any) begin
          req_gnt       = arb_gnt;
          owner_next    = arb_id;
          cur_addr_next = addr_arr[arb_id];
          rem_next      = len_arr[arb_id];
          if (len_arr[arb_id] == '0) begin
            state_next     = DRAIN;
            zlen_done_next = 1'b1;
          end else begin
            state_next = BURST;
          end
        end else begin
          state_next = IDLE;
        end
      end
      BURST: begin
        if (en) begin
          issue_en      = 1'b1;
          cur_addr_next = cur_addr_reg + ADDR_W'(1);
          rem_next      = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            issue_last = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bram_en   = issue_en;
  assign bram_addr = cur_addr_reg;

  // ---------------- latency pipeline ----------------
  for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_en_reg[gi]   <= 1'b0;
          pipe_id_reg[gi]   <= '0;
          pipe_last_reg[gi] <= 1'b0;
        end else begin
          pipe_en_reg[gi]   <= issue_en;
          pipe_id_reg[gi]   <= owner_reg;
          pipe_last_reg[gi] <= issue_last;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_en_reg[gi]   <= 1'b0;
          pipe_id_reg[gi]   <= '0;
          pipe_last_reg[gi] <= 1'b0;
        end else begin
          pipe_en_reg[gi]   <= pipe_en_reg[gi-1];
          pipe_id_reg[gi]   <= pipe_id_reg[gi-1];
          pipe_last_reg[gi] <= pipe_last_reg[gi-1];
        end
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_busy = pipe_busy | pipe_en_reg[i];
    end
  end

  // ---------------- outputs ----------------
  assign valid    = pipe_en_reg[RD_LAT-1];
  assign data_out = valid ? bram_dout : '0;
  assign data_id  = valid ? pipe_id_reg[RD_LAT-1] : '0;
  assign busy     = (state_reg != IDLE) | pipe_busy;

  // Zero-length bursts report completion from the FSM since no word ever reaches the pipeline.
  always_comb begin
    done = '0;
    if (valid && pipe_last_reg[RD_LAT-1]) done[pipe_id_reg[RD_LAT-1]] = 1'b1;
    if (zlen_done_reg) done[owner_reg] = 1'b1;
  end

endmodule

// File: tb/tb_bram_rd_sched.sv
// Scoreboard bench for bram_rd_sched: stimulus pushes expected grants/addresses/data, a monitor pops them.
module tb_bram_rd_sched;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 8;
  localparam int RD_LAT  = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       en;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*LEN_W-1:0]   req_len;
  logic [NUM_REQ-1:0]         req_gnt;
  logic                       bram_en;
  logic [ADDR_W-1:0]          bram_addr;
  logic [DATA_W-1:0]          bram_dout;
  logic [DATA_W-1:0]          data_out;
  logic                       valid;
  logic [0:0]                 data_id;
  logic                       busy;
  logic [NUM_REQ-1:0]         done;

  always #5 clk = ~clk;

  bram_rd_sched #(
    .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W),
    .LEN_W (LEN_W), .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .req (req), .req_addr (req_addr),
    .req_len (req_len), .req_gnt (req_gnt), .bram_en (bram_en),
    .bram_addr (bram_addr), .bram_dout (bram_dout), .data_out (data_out),
    .valid (valid), .data_id (data_id), .busy (busy), .done (done)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [7:0] mem_val(input logic [9:0] a);
    return a[7:0] ^ {6'b0, a[9:8]} ^ 8'hA5;
  endfunction

  // Two-cycle BRAM read model.
  logic [7:0] rd1;
  always @(posedge clk) begin
    rd1       <= bram_en ? mem_val(bram_addr) : 8'h00;
    bram_dout <= rd1;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       id;
    logic [1:0] done;
    logic       zlen;
  } exp_t;

  exp_t       data_q [$];
  logic [1:0] gnt_q  [$];
  logic [9:0] addr_q [$];

  int n_cmp = 0, n_bad = 0, gnt_seen = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every grant, issued address and returned word is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_gnt) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 32'(req_gnt), 32'h0);
        else                   check("gnt", 32'(req_gnt), 32'(gnt_q.pop_front()));
        gnt_seen++;
      end
      if (bram_en) begin
        if (addr_q.size() == 0) check("bram_en_unexpected", 32'(bram_en), 32'h0);
        else                    check("bram_addr", 32'(bram_addr), 32'(addr_q.pop_front()));
      end
      if (valid || (|done)) begin
        if (data_q.size() == 0) begin
          check("valid_unexpected", 32'(valid), 32'h0);
          check("done_unexpected", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = data_q.pop_front();
          check("valid", 32'(valid), 32'(!e.zlen));
          if (!e.zlen) begin
            check("data_out", 32'(data_out), 32'(e.data));
            check("data_id", 32'(data_id), 32'(e.id));
          end
          check("done", 32'(done), 32'(e.done));
          if (e.done != 2'b00) $display("burst complete: id=%0d cycle=%0d", e.id, cyc);
        end
      end
    end
  end

  task automatic expect_burst(input int id, input int addr, input int len);
    exp_t e;
    gnt_q.push_back(2'(1 << id));
    for (int k = 0; k < len; k++) begin
      logic [9:0] a;
      a = 10'((addr + k) % 1024);
      addr_q.push_back(a);
      e.data = mem_val(a);
      e.id   = 1'(id);
      e.done = (k == len - 1) ? 2'(1 << id) : 2'b00;
      e.zlen = 1'b0;
      data_q.push_back(e);
    end
    if (len == 0) begin
      e.data = 8'h00;
      e.id   = 1'(id);
      e.done = 2'(1 << id);
      e.zlen = 1'b1;
      data_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(idle), 32'h1);
    check({tag, "_sb_data_left"}, 32'(data_q.size()), 32'h0);
    check({tag, "_sb_addr_left"}, 32'(addr_q.size()), 32'h0);
  endtask

  task automatic run_burst(input int id, input int addr, input int len,
                           input int pause_after, input int pause_cyc);
    int issued = 0, t_first_en = -1, t_first_v = -1, t2 = -1, t3 = -1, gnt_cyc = 0;
    bit got = 1'b0, paused = 1'b0, idle = 1'b0;
    @(posedge clk); #1;
    expect_burst(id, addr, len);
    req_addr[id*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_len[id*LEN_W +: LEN_W]    = LEN_W'(len);
    req[id] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_gnt[id]) begin
        got = 1'b1;
        gnt_cyc = cyc;
        break;
      end
    end
    check("gnt_seen", 32'(got), 32'h1);
    @(posedge clk); #1;
    req[id] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bram_en) begin
        issued++;
        if (issued == 1) t_first_en = cyc;
        if (issued == 2) t2 = cyc;
        if (issued == 3) t3 = cyc;
      end
      if (valid && t_first_v < 0) t_first_v = cyc;
      if (len == 0 && cyc == gnt_cyc + 1) begin
        check("zlen_done_timing", 32'(done), 32'(1 << id));
        check("zlen_no_bram_en", 32'(bram_en), 32'h0);
      end
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      if (pause_after > 0 && issued == pause_after && !paused) begin
        paused = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (pause_cyc) @(posedge clk);
        #1;
        en = 1'b1;
      end
    end
    check("burst_idle", 32'(idle), 32'h1);
    check("words_issued", 32'(issued), 32'(len));
    if (len > 0 && pause_after <= 0) begin
      check("first_issue_after_gnt", 32'(t_first_en - gnt_cyc), 32'h1);
      check("read_latency", 32'(t_first_v - t_first_en), 32'(RD_LAT));
    end
    if (pause_after > 0) check("pause_gap", 32'(t3 - t2 - 1), 32'(pause_cyc));
    check("sb_data_left", 32'(data_q.size()), 32'h0);
    check("sb_addr_left", 32'(addr_q.size()), 32'h0);
    $display("burst id=%0d addr=0x%03h len=%0d issued=%0d", id, addr, len, issued);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, issued, vcount;
    bit got;
    rst = 1'b1; en = 1'b1; req = '0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_gnt", 32'(req_gnt), 32'h0);
    check("rst_bram_en", 32'(bram_en), 32'h0);
    check("rst_bram_addr", 32'(bram_addr), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Contention: both requesters held for four grants
    @(posedge clk); #1;
    req_addr = {10'h200, 10'h100};
    req_len  = {8'd2, 8'd2};
    for (int k = 0; k < 4; k++) begin
`ifdef BRAM_RD_FIXED_PRIO_EN
      expect_burst(0, 'h100, 2);
`else
      expect_burst(k % 2, (k % 2 == 1) ? 'h200 : 'h100, 2);
`endif
    end
    base = gnt_seen;
    got  = 1'b0;
    req  = 2'b11;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (gnt_seen == base + 4) begin
        got = 1'b1;
        break;
      end
    end
    check("contention_4_grants", 32'(got), 32'h1);
    @(posedge clk); #1;
    req = '0;
    wait_idle("contention");
    $display("contention: %0d grants observed", gnt_seen - base);

    // Single burst, pause, wrap, zero length
    run_burst(0, 'h010, 4, 0, 0);
    run_burst(1, 'h020, 6, 2, 3);
    run_burst(0, 'h3FE, 3, 0, 0);
    run_burst(1, 'h155, 0, 0, 0);

    // Reset in the middle of a burst
    @(posedge clk); #1;
    expect_burst(0, 'h050, 8);
    req_addr[9:0] = 10'h050;
    req_len[7:0]  = 8'd8;
    req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_gnt[0]) begin
        got = 1'b1;
        break;
      end
    end
    check("midrst_gnt_seen", 32'(got), 32'h1);
    @(posedge clk); #1;
    req = '0;
    issued = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bram_en) issued++;
      if (issued == 3) break;
    end
    check("midrst_words_before", 32'(issued), 32'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    data_q.delete();
    addr_q.delete();
    gnt_q.delete();
    check("midrst_bram_en", 32'(bram_en), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_bram_addr", 32'(bram_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("midrst_no_valid_after", 32'(vcount), 32'h0);
    check("midrst_idle_after", 32'(busy), 32'h0);
    $display("mid-burst reset: %0d words issued before abort", issued);

    check("final_gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
